// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32x32 multiply / divide unit for R-type MUL/MUH/DIV/MOD (signed and unsigned).
// Latency: start accepted at edge E -> done_o high E+34..E+35; divide-by-zero / signed overflow E+2..E+3.
// Backpressure: no handshake; stall_o freezes the pipeline while busy or on the accepting cycle, flush_i aborts.
//
// Ports:
//   sys_clk, rst_n        clock, async active-low reset
//   start_i, func_i,      request, func field (0110xx), selector (2 = low/quotient, 3 = high/remainder)
//   shift_amt_i
//   op_a_i, op_b_i        rs / rt operands
//   flush_i               abort in-flight operation (also drops a same-cycle start)
//   busy_o, stall_o       busy in CALC/FIX; stall = busy or start accepted (combinational)
//   done_o, illegal_o     one-cycle pulses
//   result_o              registered result, updated only in FIX
module muldiv_seq (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [5:0]  func_i,
  input  logic [4:0]  shift_amt_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        prep_q;      // first CALC cycle: form magnitudes, detect special cases
  logic [1:0]  op_q;        // func[1:0]: bit1 = divide, bit0 = unsigned
  logic        sel_q;       // 0 = low product / quotient, 1 = high product / remainder
  logic [31:0] a_q, b_q;    // raw operands as latched
  logic [31:0] mag_q;       // multiplicand magnitude or divisor magnitude
  logic [63:0] acc_q;       // mul: {partial high, multiplier}; div: [31:0] dividend/quotient
  logic [32:0] rem_q;       // partial remainder
  logic        neg_res_q, neg_rem_q, special_q;
  logic [31:0] result_q;
  logic        illegal_q;

  logic can_start, start_legal, start_acc, start_rej;
  logic is_div, is_signed;
  logic [31:0] mag_a, mag_b;
  logic div_zero, div_ovf, special;
  logic [31:0] sp_quo, sp_rem;

  assign can_start   = (state_q == IDLE) || (state_q == DONE);
  assign start_legal = (func_i[5:2] == 4'b0110) &&
                       ((shift_amt_i == 5'd2) || (shift_amt_i == 5'd3));
  // A flush in the same cycle drops the start entirely, legal or not.
  assign start_acc   = can_start && start_i && !flush_i && start_legal;
  assign start_rej   = can_start && start_i && !flush_i && !start_legal;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign mag_a     = (is_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
  assign mag_b     = (is_signed && b_q[31]) ? (32'd0 - b_q) : b_q;

  assign div_zero = is_div && (b_q == 32'd0);
  assign div_ovf  = is_div && is_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;
  assign sp_quo   = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  assign sp_rem   = div_zero ? a_q : 32'd0;

  // One iteration of shift-add multiply or restoring divide.
  logic [32:0] mul_sum;
  logic [33:0] div_shift, div_diff;
  logic [63:0] acc_step;
  logic [32:0] rem_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag_q : 32'd0)};
    div_shift = {rem_q, acc_q[31]};
    div_diff  = div_shift - {2'b00, mag_q};
    if (is_div) begin
      // Borrow out of the trial subtraction means restore (quotient bit 0).
      acc_step = {acc_q[63:32], acc_q[30:0], ~div_diff[33]};
      rem_step = div_diff[33] ? div_shift[32:0] : div_diff[32:0];
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
      rem_step = rem_q;
    end
  end

  // Sign correction and half/word selection applied in FIX.
  logic [63:0] prod;
  logic [31:0] quo, rmd, fix_res;

  always_comb begin
    prod = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quo  = (neg_res_q && !special_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rmd  = (neg_rem_q && !special_q) ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    if (is_div) begin
      fix_res = sel_q ? rmd : quo;
    end else begin
      fix_res = sel_q ? prod[63:32] : prod[31:0];
    end
  end

  // FSM: state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start_acc ? CALC : IDLE;
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (prep_q) begin
          state_d = special ? FIX : CALC;
        end else if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = flush_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o  = (state_q == CALC) || (state_q == FIX);
    done_o  = (state_q == DONE);
    stall_o = busy_o || start_acc;
  end

  assign result_o  = result_q;
  assign illegal_o = illegal_q;

  // Datapath
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 5'd0;
      prep_q    <= 1'b0;
      op_q      <= 2'd0;
      sel_q     <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      mag_q     <= 32'd0;
      acc_q     <= 64'd0;
      rem_q     <= 33'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      result_q  <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= start_rej;
      if (start_acc) begin
        a_q    <= op_a_i;
        b_q    <= op_b_i;
        op_q   <= func_i[1:0];
        sel_q  <= shift_amt_i[0];
        cnt_q  <= 5'd0;
        prep_q <= 1'b1;
      end else if ((state_q == CALC) && !flush_i) begin
        if (prep_q) begin
          prep_q    <= 1'b0;
          neg_res_q <= is_signed && (a_q[31] ^ b_q[31]);
          neg_rem_q <= is_signed && a_q[31];
          special_q <= special;
          if (special) begin
            acc_q <= {32'd0, sp_quo};
            rem_q <= {1'b0, sp_rem};
          end else if (is_div) begin
            acc_q <= {32'd0, mag_a};
            rem_q <= 33'd0;
            mag_q <= mag_b;
          end else begin
            acc_q <= {32'd0, mag_b};
            rem_q <= 33'd0;
            mag_q <= mag_a;
          end
        end else begin
          cnt_q <= cnt_q + 5'd1;
          acc_q <= acc_step;
          rem_q <= rem_step;
        end
      end else if ((state_q == FIX) && !flush_i) begin
        result_q <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq.
// Latency: measured from the accepting edge to the first sample with done_o high.
// Backpressure: exercises stall_o, busy-time starts, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  func_i = 6'd0;
  logic [4:0]  shift_amt_i = 5'd0;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, done_o, illegal_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  int n;

  localparam logic [5:0] F_MUL  = 6'b011000;
  localparam logic [5:0] F_MULU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_BAD  = 6'b011100;

  muldiv_seq dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .func_i      (func_i),
    .shift_amt_i (shift_amt_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .illegal_o   (illegal_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Drive a legal request now, confirm stall_o, and let one rising edge accept it.
  task automatic start_op(input logic [5:0] f, input logic [4:0] s,
                          input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; func_i = f; shift_amt_i = s; op_a_i = a; op_b_i = b;
    #1;
    chk("stall on start", 32'(stall_o), 32'd1);
    @(posedge sys_clk);
    #1 start_i = 1'b0;
  endtask

  // lat counts rising edges after the accepting one; ends on the sample where done_o is high.
  task automatic wait_done(input string tag, input logic [31:0] exp,
                           input int exp_lat, input int lat0);
    int   lat;
    logic b1;
    lat = lat0;
    b1  = 1'b0;
    @(negedge sys_clk);
    while (!done_o && lat < 80) begin
      if (lat == 1) b1 = busy_o;
      @(negedge sys_clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result_o, exp);
    if (lat0 <= 1) chk({tag, " busy"}, 32'(b1), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [5:0] f, input logic [4:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
    @(negedge sys_clk);
    start_op(f, s, a, b);
    wait_done(tag, exp, exp_lat, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst illegal", 32'(illegal_o), 32'd0);
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst result", result_o, 32'd0);

    // First start on the first edge after reset release
    rst_n = 1'b1;
    start_op(F_MUL, 5'd2, 32'd7, 32'd6);
    wait_done("mul", 32'd42, 34, 0);
    @(negedge sys_clk);
    chk("done one cycle", 32'(done_o), 32'd0);
    chk("idle busy", 32'(busy_o), 32'd0);

    do_op("muh",      F_MUL,  5'd3, 32'd7,          32'd6,          32'd0,          34);
    do_op("muh neg",  F_MUL,  5'd3, 32'h8000_0000,  32'd2,          32'hFFFF_FFFF,  34);
    do_op("muhu",     F_MULU, 5'd3, 32'h8000_0000,  32'd2,          32'h0000_0001,  34);
    do_op("mul neg",  F_MUL,  5'd2, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  34);
    do_op("div",      F_DIV,  5'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
    do_op("mod",      F_DIV,  5'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
    do_op("divu",     F_DIVU, 5'd2, 32'd7,          32'd2,          32'd3,          34);
    do_op("divu0",    F_DIVU, 5'd2, 32'd5,          32'd0,          32'hFFFF_FFFF,  2);
    do_op("mod0",     F_DIV,  5'd3, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  2);
    do_op("ovf mod",  F_DIV,  5'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2);
    do_op("ovf div",  F_DIV,  5'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2);

    // Flush mid-CALC, then an immediate new operation
    @(negedge sys_clk);
    start_op(F_MUL, 5'd2, 32'd3, 32'd4);
    repeat (11) @(negedge sys_clk);
    flush_i = 1'b1;
    @(posedge sys_clk);
    #1 flush_i = 1'b0;
    @(negedge sys_clk);
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush done", 32'(done_o), 32'd0);
    chk("flush result kept", result_o, 32'h8000_0000);
    start_op(F_MUL, 5'd2, 32'd5, 32'd5);
    wait_done("after flush", 32'd25, 34, 0);

    // Flush and start together: start dropped
    @(negedge sys_clk);
    start_i = 1'b1; func_i = F_MUL; shift_amt_i = 5'd2; op_a_i = 32'd9; op_b_i = 32'd9;
    flush_i = 1'b1;
    #1;
    chk("flush+start stall", 32'(stall_o), 32'd0);
    @(posedge sys_clk);
    #1 begin start_i = 1'b0; flush_i = 1'b0; end
    @(negedge sys_clk);
    chk("flush+start busy", 32'(busy_o), 32'd0);
    chk("flush+start illegal", 32'(illegal_o), 32'd0);

    // Back-to-back: second start issued while in DONE
    @(negedge sys_clk);
    start_op(F_DIVU, 5'd2, 32'd100, 32'd7);
    wait_done("b2b first", 32'd14, 34, 0);
    start_op(F_DIVU, 5'd3, 32'd100, 32'd7);
    wait_done("b2b second", 32'd2, 34, 0);

    // Starts while busy are ignored (legal and illegal func)
    @(negedge sys_clk);
    start_op(F_MUL, 5'd2, 32'd9, 32'd9);
    repeat (4) @(negedge sys_clk);
    start_i = 1'b1; func_i = F_DIVU; shift_amt_i = 5'd2; op_a_i = 32'd100; op_b_i = 32'd7;
    @(posedge sys_clk);
    #1 start_i = 1'b0;
    @(negedge sys_clk);
    chk("busy start busy", 32'(busy_o), 32'd1);
    start_i = 1'b1; func_i = F_BAD;
    @(posedge sys_clk);
    #1 start_i = 1'b0;
    @(negedge sys_clk);
    chk("busy bad func no illegal", 32'(illegal_o), 32'd0);
    wait_done("busy ignored", 32'd81, 34, 6);

    // Illegal func from IDLE
    @(negedge sys_clk);
    start_i = 1'b1; func_i = F_BAD; shift_amt_i = 5'd2; op_a_i = 32'd1; op_b_i = 32'd1;
    #1;
    chk("illegal stall", 32'(stall_o), 32'd0);
    @(posedge sys_clk);
    #1 start_i = 1'b0;
    @(negedge sys_clk);
    chk("illegal pulse", 32'(illegal_o), 32'd1);
    chk("illegal busy", 32'(busy_o), 32'd0);
    chk("illegal result kept", result_o, 32'd81);
    @(negedge sys_clk);
    chk("illegal one cycle", 32'(illegal_o), 32'd0);
    start_i = 1'b1; func_i = F_MUL; shift_amt_i = 5'd4;
    @(posedge sys_clk);
    #1 start_i = 1'b0;
    @(negedge sys_clk);
    chk("illegal selector", 32'(illegal_o), 32'd1);

    // Reset asserted mid-CALC
    @(negedge sys_clk);
    start_op(F_MUL, 5'd2, 32'd11, 32'd11);
    repeat (10) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy_o), 32'd0);
    chk("midrst done", 32'(done_o), 32'd0);
    chk("midrst illegal", 32'(illegal_o), 32'd0);
    chk("midrst stall", 32'(stall_o), 32'd0);
    chk("midrst result", result_o, 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (done_o) n++;
    end
    chk("midrst no done", 32'(n), 32'd0);
    do_op("post reset muhu", F_MULU, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The port list SHALL begin with: sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-002 The next port SHALL be: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 start_i  input  1  request; sampled at a rising edge only while the state is IDLE or DONE.
REQ-004 func_i  input  6  R-type func field; 011000 MUL/MUH, 011001 MULU/MUHU, 011010 DIV/MOD, 011011 DIVU/MODU.
REQ-005 shift_amt_i  input  5  selector; 2 = low product or quotient, 3 = high product or remainder.
REQ-006 op_a_i  input  32  rs value (multiplicand or dividend).
REQ-007 op_b_i  input  32  rt value (multiplier or divisor).
REQ-008 flush_i  input  1  abort the in-flight operation.
REQ-009 busy_o  output  1  high in CALC and FIX.
REQ-010 stall_o  output  1  high when busy_o is high or a start is accepted; combinational, for pipeline freeze.
REQ-011 done_o  output  1  one-cycle pulse, high in DONE.
REQ-012 result_o  output  32  selected 32-bit result, registered.
REQ-013 illegal_o  output  1  one-cycle pulse when a start is rejected as illegal.

Function
REQ-014 States SHALL be IDLE, CALC, FIX and DONE, encoded in 2 bits.
REQ-015 Legality rule: a start is legal when func_i[5:2]=0110 and shift_amt_i is 2 or 3.
REQ-016 Legal start: the block SHALL latch operands, func_i[1:0] and the selector, and move to CALC with a 5-bit counter = 0.
REQ-017 Illegal start: the block SHALL stay in IDLE, pulse illegal_o for one cycle, and leave result_o unchanged.
REQ-018 Signed ops (func_i[0]=0): the block SHALL operate on operand magnitudes and record the result signs.
REQ-019 Sign rule: product sign = sign_a XOR sign_b; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
REQ-020 Multiply: radix-2 shift-add, one multiplier bit per cycle into a 64-bit accumulator.
REQ-021 Divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-022 CALC SHALL run exactly 32 cycles (counter 0..31), then go to FIX.
REQ-023 FIX SHALL apply two's-complement sign correction, select the 32-bit half or word, load result_o, and go to DONE.
REQ-024 Timing: start sampled at edge E gives done_o = 1 from edge E+34 to edge E+35.
REQ-025 DONE SHALL last one cycle, then go to IDLE, or straight to CALC if start_i is accepted (back-to-back).
REQ-026 Divide by zero: the block SHALL skip CALC and go to FIX at E+1, with quotient = 0xFFFFFFFF and remainder = op_a_i for both signed and unsigned.
REQ-027 Signed overflow (0x80000000 / 0xFFFFFFFF): the block SHALL skip CALC, with quotient = 0x80000000 and remainder = 0.
REQ-028 Special-case timing: done_o SHALL be high from edge E+2 to edge E+3.
REQ-029 start_i asserted while in CALC or FIX SHALL be ignored: no state effect, no illegal_o.
REQ-030 flush_i high at an edge in CALC or FIX SHALL force IDLE, with no done_o and result_o unchanged.
REQ-031 flush_i and start_i high together SHALL drop the start: the block goes to IDLE and stall_o stays 0.
REQ-032 result_o SHALL hold its value until the next FIX.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, counter=0, accumulator/remainder=0, result_o=0, busy_o=0, done_o=0, illegal_o=0.
REQ-034 Reset asserted mid-CALC SHALL discard the operation; after release no done_o is produced.
REQ-035 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-036 MUL: a=7, b=6, shamt=2 -> result_o=42 and done_o at E+34; MUH with the same operands -> 0.
REQ-037 Signed high product: MUH a=0x80000000, b=2 -> 0xFFFFFFFF; MUHU with the same operands -> 0x00000001.
REQ-038 Signed divide: DIV a=-7, b=2 -> 0xFFFFFFFD; MOD -> 0xFFFFFFFF; DIVU a=7, b=2 -> 3.
REQ-039 Special cases: DIVU a=5, b=0 -> 0xFFFFFFFF at E+2; MOD a=0x80000000, b=0xFFFFFFFF -> 0 at E+2; check stall_o and busy_o.
REQ-040 Flush: flush_i at CALC cycle 10 -> IDLE, no done_o, result_o keeps its old value; an immediate new start completes correctly.
REQ-041 Back-to-back starts, a start during busy (ignored), an illegal func 011100 -> illegal_o pulse, and rst_n low mid-CALC -> all outputs 0.
